// File: rtl/irq_stim_gen.sv
// Multi-channel interrupt stimulus generator: each channel fires its line on a PC match,
// after a programmable delay, a programmable number of times, and drops on ack or after a pulse.
module irq_stim_gen #(
    parameter int          NUM_CH   = 4,
    parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
    parameter int          DELAY_W  = 8,
    parameter int          CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_ch,
    input  logic [31:0]        cfg_trig_pc,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0]   cfg_count,
    input  logic               cfg_pulse,
    input  logic [31:0]        macroscopic_pc,
    input  logic [31:0]        m_data_addr,
    input  logic [31:0]        m_data_wdata,
    input  logic [3:0]         m_data_byteen,
    output logic [NUM_CH-1:0]  interrupt,
    output logic               irq_any,
    output logic [15:0]        fire_total
);

    typedef enum logic [1:0] {IDLE, ARMED, WAIT, ASSERT} state_t;

    // An all-ones count means unlimited fires and is never decremented.
    function automatic logic [CNT_W-1:0] count_after_fire(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt - CNT_W'(1);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {13'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic              ack;
    logic [NUM_CH-1:0] ack_mask;
    logic [NUM_CH-1:0] ack_vec;
    logic [NUM_CH-1:0] enter;
    logic [3:0]        fire_inc;
    logic              unused_bits;

    assign ack      = (|m_data_byteen) && (m_data_addr[31:2] == ACK_ADDR[31:2]);
    assign ack_mask = m_data_wdata[NUM_CH-1:0];
    assign ack_vec  = (ack_mask == '0) ? {NUM_CH{ack}} : ({NUM_CH{ack}} & ack_mask);

    assign unused_bits = ^{macroscopic_pc[1:0], m_data_addr[1:0], cfg_trig_pc[1:0],
                           m_data_wdata[31:NUM_CH]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t             state;
        logic [31:2]        trig;
        logic [DELAY_W-1:0] delay;
        logic [DELAY_W-1:0] timer;
        logic [CNT_W-1:0]   count;
        logic [CNT_W-1:0]   count_next;
        logic               pulse;
        logic               match_prev;
        logic               irq_q;
        logic               cfg_hit;
        logic               match;
        logic               rise;
        logic               leave;

        assign cfg_hit    = cfg_we && (cfg_ch == 3'(c));
        assign match      = (macroscopic_pc[31:2] == trig);
        assign rise       = match && !match_prev;
        assign leave      = (state == ASSERT) && (pulse || ack_vec[c]);
        assign count_next = count_after_fire(count);
        assign enter[c]   = !cfg_hit &&
                            (((state == ARMED) && rise && (delay == '0)) ||
                             ((state == WAIT) && (timer == DELAY_W'(1))));
        assign interrupt[c] = irq_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state      <= IDLE;
                trig       <= '0;
                delay      <= '0;
                timer      <= '0;
                count      <= '0;
                pulse      <= 1'b0;
                match_prev <= 1'b0;
                irq_q      <= 1'b0;
            end else if (cfg_hit) begin
                // Reconfiguration wins over ack and trigger and restarts edge detection.
                trig       <= cfg_trig_pc[31:2];
                delay      <= cfg_delay;
                count      <= cfg_count;
                pulse      <= cfg_pulse;
                timer      <= '0;
                match_prev <= 1'b0;
                irq_q      <= 1'b0;
                state      <= (cfg_count != '0) ? ARMED : IDLE;
            end else begin
                match_prev <= match;
                case (state)
                    ARMED: begin
                        if (rise) begin
                            if (delay == '0) begin
                                state <= ASSERT;
                                irq_q <= 1'b1;
                            end else begin
                                timer <= delay;
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (timer == DELAY_W'(1)) begin
                            state <= ASSERT;
                            irq_q <= 1'b1;
                        end else begin
                            timer <= timer - DELAY_W'(1);
                        end
                    end
                    ASSERT: begin
                        if (leave) begin
                            irq_q <= 1'b0;
                            count <= count_next;
                            state <= (count_next != '0) ? ARMED : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        fire_inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fire_inc = fire_inc + 4'(enter[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_total <= '0;
        end else begin
            fire_total <= sat_add16(fire_total, fire_inc);
        end
    end

    assign irq_any = |interrupt;

endmodule

// File: tb/tb_irq_stim_gen.sv
// Bench for irq_stim_gen: directed scenarios plus randomized traffic against a
// time-scheduled behavioural model of the channels.
module tb_irq_stim_gen;
    localparam int          NUM_CH  = 4;
    localparam int          DELAY_W = 8;
    localparam int          CNT_W   = 8;
    localparam logic [31:0] ACK     = 32'h0000_7F20;
    localparam int          UNLIM   = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [2:0]         cfg_ch;
    logic [31:0]        cfg_trig_pc;
    logic [DELAY_W-1:0] cfg_delay;
    logic [CNT_W-1:0]   cfg_count;
    logic               cfg_pulse;
    logic [31:0]        macroscopic_pc;
    logic [31:0]        m_data_addr;
    logic [31:0]        m_data_wdata;
    logic [3:0]         m_data_byteen;
    logic [NUM_CH-1:0]  interrupt;
    logic               irq_any;
    logic [15:0]        fire_total;

    irq_stim_gen #(.NUM_CH(NUM_CH), .ACK_ADDR(ACK), .DELAY_W(DELAY_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_trig_pc(cfg_trig_pc), .cfg_delay(cfg_delay), .cfg_count(cfg_count),
        .cfg_pulse(cfg_pulse), .macroscopic_pc(macroscopic_pc), .m_data_addr(m_data_addr),
        .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen), .interrupt(interrupt),
        .irq_any(irq_any), .fire_total(fire_total)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a triggered channel records the absolute cycle its line must be high.
    logic [31:0] m_trig     [NUM_CH];
    int          m_delay    [NUM_CH];
    int          m_count    [NUM_CH];
    bit          m_pulse    [NUM_CH];
    bit          m_armed    [NUM_CH];
    bit          m_asserted [NUM_CH];
    longint      m_due      [NUM_CH];
    bit          m_prev     [NUM_CH];
    int          m_total;
    longint      ncyc;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_trig[c] = 0; m_delay[c] = 0; m_count[c] = 0; m_pulse[c] = 0;
            m_armed[c] = 0; m_asserted[c] = 0; m_due[c] = -1; m_prev[c] = 0;
        end
        m_total = 0;
        ncyc    = 0;
    endtask

    task automatic model_fire(input int c);
        m_asserted[c] = 1;
        m_due[c]      = -1;
        if (m_total < 65535) m_total++;
    endtask

    task automatic model_step();
        bit       ack_hit;
        bit [3:0] mask;
        ack_hit = (m_data_byteen != 0) && ((m_data_addr & ~32'h3) == ACK);
        mask    = m_data_wdata[3:0];
        for (int c = 0; c < NUM_CH; c++) begin
            bit match, rise;
            match = ((macroscopic_pc & ~32'h3) == (m_trig[c] & ~32'h3));
            rise  = match && !m_prev[c];
            if (cfg_we && int'(cfg_ch) == c) begin
                m_trig[c] = cfg_trig_pc; m_delay[c] = int'(cfg_delay);
                m_count[c] = int'(cfg_count); m_pulse[c] = cfg_pulse;
                m_asserted[c] = 0; m_due[c] = -1; m_prev[c] = 0;
                m_armed[c] = (m_count[c] != 0);
            end else begin
                m_prev[c] = match;
                if (m_asserted[c]) begin
                    if (m_pulse[c] || (ack_hit && (mask == 0 || mask[c]))) begin
                        m_asserted[c] = 0;
                        if (m_count[c] != UNLIM) m_count[c]--;
                        m_armed[c] = (m_count[c] != 0);
                    end
                end else if (m_due[c] >= 0) begin
                    if (m_due[c] == ncyc + 1) model_fire(c);
                end else if (m_armed[c] && rise) begin
                    m_due[c] = ncyc + m_delay[c] + 1;
                    if (m_due[c] == ncyc + 1) model_fire(c);
                end
            end
        end
        ncyc++;
    endtask

    function automatic logic [NUM_CH-1:0] model_irq();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_asserted[c];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("irq_vec", 32'(interrupt), 32'(model_irq()));
        check("irq_any", 32'(irq_any), 32'(|model_irq()));
        check("fire_total", 32'(fire_total), 32'(m_total));
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_ch = 0; cfg_trig_pc = 0; cfg_delay = 0; cfg_count = 0; cfg_pulse = 0;
        macroscopic_pc = 32'h100; m_data_addr = 0; m_data_wdata = 0; m_data_byteen = 0;
    endtask

    task automatic cfg(input int ch, input logic [31:0] trig, input int dly, input int cnt,
                       input bit pls);
        cfg_we = 1; cfg_ch = 3'(ch); cfg_trig_pc = trig; cfg_delay = DELAY_W'(dly);
        cfg_count = CNT_W'(cnt); cfg_pulse = pls;
        tick();
        cfg_we = 0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        m_data_addr = addr; m_data_wdata = data; m_data_byteen = be;
        tick();
        m_data_byteen = 0;
    endtask

    task automatic pc_hit(input logic [31:0] pc);
        macroscopic_pc = pc;
        tick();
        macroscopic_pc = 32'h100;
    endtask

    initial begin
        int t0;
        idle_inputs();
        reset = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", 32'(interrupt), 32'h0);
        check("rst_any", 32'(irq_any), 32'h0);
        check("rst_total", 32'(fire_total), 32'h0);
        reset = 0;

        // Level channel, immediate fire, global ack, no refire once count is spent.
        cfg(0, 32'h3018, 0, 1, 0);
        pc_hit(32'h3018);
        check("t1_rise", 32'(interrupt[0]), 32'h1);
        tick();
        check("t1_hold", 32'(interrupt[0]), 32'h1);
        store(ACK, 32'h0, 4'hF);
        check("t1_ack", 32'(interrupt[0]), 32'h0);
        pc_hit(32'h3018);
        tick();
        check("t1_norefire", 32'(interrupt[0]), 32'h0);

        // Pulse channel with delay 5, two fires, then spent.
        cfg(1, 32'h3040, 5, 2, 1);
        for (int k = 0; k < 2; k++) begin
            pc_hit(32'h3042);
            repeat (4) tick();
            check("t2_early", 32'(interrupt[1]), 32'h0);
            tick();
            check("t2_pulse", 32'(interrupt[1]), 32'h1);
            tick();
            check("t2_drop", 32'(interrupt[1]), 32'h0);
        end
        check("t2_total", 32'(fire_total), 32'd3);
        pc_hit(32'h3040);
        repeat (8) tick();
        check("t2_spent", 32'(fire_total), 32'd3);

        // Masked acks; wrong address and zero byte enables must not ack.
        cfg(0, 32'h3050, 0, 1, 0);
        cfg(2, 32'h3050, 0, 1, 0);
        pc_hit(32'h3050);
        check("t3_both", 32'(interrupt), 32'h5);
        store(32'h7F24, 32'h0, 4'hF);
        check("t6_addr", 32'(interrupt), 32'h5);
        store(ACK, 32'h0, 4'h0);
        check("t6_byteen", 32'(interrupt), 32'h5);
        store(ACK | 32'h3, 32'h4, 4'h1);
        check("t3_ch2", 32'(interrupt), 32'h1);
        store(ACK, 32'h1, 4'h2);
        check("t3_ch0", 32'(interrupt), 32'h0);

        // PC held on the trigger with continuous acks fires only once.
        cfg(3, 32'h3060, 0, UNLIM, 0);
        t0 = m_total;
        macroscopic_pc = 32'h3060; m_data_addr = ACK; m_data_wdata = 0; m_data_byteen = 4'hF;
        repeat (10) tick();
        idle_inputs();
        tick();
        check("t4_once", 32'(fire_total), 32'(t0 + 1));
        pc_hit(32'h3060);
        check("t4_return", 32'(interrupt[3]), 32'h1);
        cfg(3, 32'h3060, 0, 0, 0);

        // Reconfigure during the delay cancels the fire.
        cfg(1, 32'h3070, 5, 1, 0);
        pc_hit(32'h3070);
        repeat (2) tick();
        t0 = m_total;
        cfg(1, 32'h3070, 5, 0, 0);
        repeat (8) tick();
        check("t5_cancel", 32'(interrupt[1]), 32'h0);
        check("t5_total", 32'(fire_total), 32'(t0));

        // Asynchronous reset while a line is high.
        cfg(2, 32'h3080, 0, 1, 0);
        pc_hit(32'h3080);
        check("t5_asserted", 32'(interrupt[2]), 32'h1);
        #2 reset = 1;
        #1;
        check("t5_async_irq", 32'(interrupt), 32'h0);
        check("t5_async_total", 32'(fire_total), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        model_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            if ($urandom_range(0, 3) != 0)
                macroscopic_pc = 32'h3000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                int pick;
                cfg_we = 1;
                cfg_ch = 3'($urandom_range(0, 7));
                cfg_trig_pc = 32'h3000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
                cfg_delay = ($urandom_range(0, 9) == 0) ? DELAY_W'($urandom_range(0, 30))
                                                        : DELAY_W'($urandom_range(0, 4));
                pick = $urandom_range(0, 5);
                cfg_count = (pick == 0) ? '0 : (pick == 1) ? CNT_W'(UNLIM)
                                                           : CNT_W'($urandom_range(1, 3));
                cfg_pulse = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) begin
                m_data_byteen = 4'($urandom_range(0, 15));
                m_data_addr = (($urandom_range(0, 4) == 0) ? 32'h7F24 : ACK)
                              | 32'($urandom_range(0, 3));
                m_data_wdata = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
